// File: rtl/bus_copy_sequencer_pkg.sv
// ============================================================================
// Module : copy_seq_pkg
// Shared state encoding and word size for the bus copy sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package copy_seq_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    FINISH  = 3'd4
  } copy_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/bus_copy_sequencer_if.sv
// ============================================================================
// Module : bus_copy_sequencer_if
// Simple request/valid memory bus between the copy sequencer and its follower.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bus_copy_sequencer_if;
  logic [31:0] addr;
  logic        read_req;
  logic        write_req;
  logic [3:0]  byte_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_data_valid;

  modport master (
    output addr, read_req, write_req, byte_enable, write_data,
    input  read_data, read_data_valid
  );

  modport slave (
    input  addr, read_req, write_req, byte_enable, write_data,
    output read_data, read_data_valid
  );
endinterface

`default_nettype wire

// File: rtl/bus_copy_sequencer.sv
// ============================================================================
// Module : bus_copy_sequencer
// Copies Words source words to a destination address range, one read then one
// write per word. Optional loop mode under macro COPY_SEQ_LOOP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_copy_sequencer
  import copy_seq_pkg::*;
#(
  parameter logic [31:0] SrcBase    = 32'h2000_0000,
  parameter logic [31:0] DstBase    = 32'h1000_0000,
  parameter int unsigned Words      = 5,
  parameter logic [31:0] DstStride  = 32'd0,
  parameter logic [3:0]  ByteEnable = 4'h1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
`ifdef COPY_SEQ_LOOP_EN
  input  logic        loop_en,
`endif
  bus_copy_sequencer_if.master bus,
  output logic        busy,
  output logic        done,
  output logic [31:0] last_data
);

  localparam int unsigned   IdxW    = $clog2(Words + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Words - 1);

  copy_seq_state_t state_q;
  logic [IdxW-1:0] index_q;
  logic [31:0]     data_q;
  logic [31:0]     addr_q;
  logic            rd_req_q;
  logic            wr_req_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic            busy_q;
  logic            done_q;

  logic [31:0]     src_next_d;
  logic [31:0]     dst_addr_d;

  // Outputs are registered, so addresses are computed for the state being entered.
  assign src_next_d = SrcBase + 32'(WORD_BYTES) * (32'(index_q) + 32'd1);
  assign dst_addr_d = DstBase + DstStride * 32'(index_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      index_q  <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RD_REQ;
            index_q  <= '0;
            busy_q   <= 1'b1;
            rd_req_q <= 1'b1;
            addr_q   <= SrcBase;
          end
        end
        RD_REQ: begin
          state_q  <= RD_WAIT;
          rd_req_q <= 1'b0;
          addr_q   <= '0;
        end
        RD_WAIT: begin
          if (bus.read_data_valid) begin
            state_q  <= WR;
            data_q   <= bus.read_data;
            wdata_q  <= bus.read_data;
            wr_req_q <= 1'b1;
            be_q     <= ByteEnable;
            addr_q   <= dst_addr_d;
          end
        end
        WR: begin
          wr_req_q <= 1'b0;
          be_q     <= '0;
          wdata_q  <= '0;
          if (index_q == LastIdx) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
            addr_q  <= '0;
          end else begin
            state_q  <= RD_REQ;
            index_q  <= index_q + IdxW'(1);
            rd_req_q <= 1'b1;
            addr_q   <= src_next_d;
          end
        end
        FINISH: begin
          done_q <= 1'b0;
`ifdef COPY_SEQ_LOOP_EN
          if (loop_en) begin
            state_q  <= RD_REQ;
            index_q  <= '0;
            rd_req_q <= 1'b1;
            addr_q   <= SrcBase;
          end else
`endif
          begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.addr        = addr_q;
  assign bus.read_req    = rd_req_q;
  assign bus.write_req   = wr_req_q;
  assign bus.byte_enable = be_q;
  assign bus.write_data  = wdata_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign last_data       = data_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_copy_sequencer.sv
// ============================================================================
// Module : tb_bus_copy_sequencer
// Directed bench: default instance with a variable-latency ROM follower and a
// Words=3/DstStride=4 instance with a latency-1 follower.
// ============================================================================
`default_nettype none

module tb_bus_copy_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic start;
`ifdef COPY_SEQ_LOOP_EN
  logic loop_en;
`endif

  bus_copy_sequencer_if bus0 ();
  bus_copy_sequencer_if bus1 ();

  logic        busy0, done0, busy1, done1;
  logic [31:0] last0, last1;

  bus_copy_sequencer dut0 (
    .clk(clk), .reset_n(reset_n), .start(start),
`ifdef COPY_SEQ_LOOP_EN
    .loop_en(loop_en),
`endif
    .bus(bus0), .busy(busy0), .done(done0), .last_data(last0)
  );

  bus_copy_sequencer #(.Words(3), .DstStride(32'd4)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start),
`ifdef COPY_SEQ_LOOP_EN
    .loop_en(1'b0),
`endif
    .bus(bus1), .busy(busy1), .done(done1), .last_data(last1)
  );

  logic [31:0] rom [8] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003,
                           32'h5555_0004, 32'h6666_0005, 32'h7777_0006, 32'h8888_0007};

  function automatic logic [31:0] rom_at(input logic [31:0] a);
    logic [31:0] o;
    o = (a - 32'h2000_0000) >> 2;
    return rom[o[2:0]];
  endfunction

  // Followers: a request sampled at an edge returns valid data lat edges later.
  int          lat0 = 1;
  logic        inject0 = 1'b0;
  logic [7:0]  pend0 = '0;
  logic [7:0]  pend1 = '0;
  logic [31:0] pa0 [8];
  logic [31:0] pa1 [8];

  always @(posedge clk) begin
    pend0 <= {pend0[6:0], bus0.read_req};
    pend1 <= {pend1[6:0], bus1.read_req};
    pa0[0] <= bus0.addr;
    pa1[0] <= bus1.addr;
    for (int i = 1; i < 8; i++) begin
      pa0[i] <= pa0[i-1];
      pa1[i] <= pa1[i-1];
    end
  end

  assign bus0.read_data_valid = pend0[lat0] | inject0;
  assign bus0.read_data       = rom_at(pa0[lat0]);
  assign bus1.read_data_valid = pend1[1];
  assign bus1.read_data       = rom_at(pa1[1]);

  int          cyc = 0;
  int          rd0 = 0;
  int          dn0 = 0;
  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
  logic [3:0]  wb0[$];
  int          wc0[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus0.write_req) begin
      wa0.push_back(bus0.addr);
      wd0.push_back(bus0.write_data);
      wb0.push_back(bus0.byte_enable);
      wc0.push_back(cyc);
    end
    if (bus0.read_req) rd0 = rd0 + 1;
    if (done0) dn0 = dn0 + 1;
    if (bus1.write_req) begin
      wa1.push_back(bus1.addr);
      wd1.push_back(bus1.write_data);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    wa0.delete(); wd0.delete(); wb0.delete(); wc0.delete();
    wa1.delete(); wd1.delete();
    rd0 = 0;
    dn0 = 0;
  endtask

  typedef struct {
    int lat;
    int hold;
    int exp_done;
    int exp_first_wr;
    int exp_gap;
  } pass_vec_t;

  pass_vec_t vecs [3];
  logic [31:0] exp_dst1 [3];

  initial begin
    int p, n, done_n;

    vecs[0] = '{lat: 1, hold: 1,  exp_done: 21, exp_first_wr: 4, exp_gap: 4};
    vecs[1] = '{lat: 4, hold: 1,  exp_done: 36, exp_first_wr: 7, exp_gap: 7};
    vecs[2] = '{lat: 2, hold: 10, exp_done: 26, exp_first_wr: 5, exp_gap: 5};
    exp_dst1[0] = 32'h1000_0000;
    exp_dst1[1] = 32'h1000_0004;
    exp_dst1[2] = 32'h1000_0008;

    reset_n = 1'b0;
    start   = 1'b0;
`ifdef COPY_SEQ_LOOP_EN
    loop_en = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_last", last0, 32'd0);
    check("rst_addr", bus0.addr, 32'd0);
    check("rst_reqs", {30'd0, bus0.read_req, bus0.write_req}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      lat0 = vecs[v].lat;
      clear_mon();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 p = cyc;
      n = 0;
      done_n = -1;
      while (n < 400 && (done_n < 0 || n < done_n + 30)) begin
        @(negedge clk);
        n++;
        start = (n < vecs[v].hold);
        if (n == 1) begin
          check("pass_busy", 32'(busy0), 32'd1);
          check("first_rd_addr", bus0.addr, 32'h2000_0000);
          check("first_rd_req", 32'(bus0.read_req), 32'd1);
        end
        if (n == 2)
          check("wait_idle_bus", bus0.addr | 32'(bus0.read_req) | 32'(bus0.write_req), 32'd0);
        if (done0 && done_n < 0) done_n = n;
        if (done_n >= 0 && n == done_n + 1) check("post_busy", 32'(busy0), 32'd0);
      end
      start = 1'b0;
      check("done_cycle", done_n, vecs[v].exp_done);
      check("done_pulses", dn0, 32'd1);
      check("read_count", rd0, 32'd5);
      check("write_count", wa0.size(), 32'd5);
      check("last_data", last0, rom[4]);
      if (wa0.size() == 5) begin
        check("first_wr_cycle", wc0[0] - p + 1, vecs[v].exp_first_wr);
        for (int i = 0; i < 5; i++) begin
          check("wr_addr", wa0[i], 32'h1000_0000);
          check("wr_data", wd0[i], rom[i]);
          check("wr_be", 32'(wb0[i]), 32'd1);
          if (i > 0) check("wr_gap", wc0[i] - wc0[i-1], vecs[v].exp_gap);
        end
      end
      check("w3_count", wa1.size(), 32'd3);
      if (wa1.size() == 3) begin
        for (int i = 0; i < 3; i++) begin
          check("w3_addr", wa1[i], exp_dst1[i]);
          check("w3_data", wd1[i], rom[i]);
        end
      end
      check("w3_last", last1, rom[2]);
    end

    // Reset during RD_WAIT; the follower's reply then arrives late.
    lat0 = 4;
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    inject0 = 1'b1;
    @(negedge clk);
    inject0 = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_writes", wa0.size(), 32'd0);
    check("abort_reads", rd0, 32'd1);
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_done", dn0, 32'd0);
    check("abort_last", last0, 32'd0);
    check("abort_addr", bus0.addr, 32'd0);

`ifdef COPY_SEQ_LOOP_EN
    lat0 = 1;
    clear_mon();
    loop_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("loop_done1", 32'(done0), 32'd1);
    @(negedge clk);
    check("loop_restart_req", 32'(bus0.read_req), 32'd1);
    check("loop_restart_addr", bus0.addr, 32'h2000_0000);
    loop_en = 1'b0;
    n = 0;
    while (!done0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("loop_done2", 32'(done0), 32'd1);
    repeat (3) @(negedge clk);
    check("loop_stop_busy", 32'(busy0), 32'd0);
    check("loop_writes", wa0.size(), 32'd10);
    check("loop_dones", dn0, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
